// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory responder.
package lsu_pkg;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        MM_B    = 3'b000,
        MM_H    = 3'b001,
        MM_W    = 3'b010,
        MM_BU   = 3'b011,
        MM_HU   = 3'b100,
        MM_NONE = 3'b111
    } mem_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Word-bus between the load/store responder (master) and data memory (slave).
interface lsu_mem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    import lsu_pkg::*;

    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [BE_W-1:0]     bus_be;
    logic [LANE_W-1:0]   bus_wdata;
    logic                bus_ack;
    logic [LANE_W-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, byte enables, store replication,
// and load byte/half extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        mode,
    input  logic [1:0]        off,
    input  logic              is_store,
    input  logic [LANE_W-1:0] wdata,
    output logic              legal,
    output logic [BE_W-1:0]   be,
    output logic [LANE_W-1:0] wdata_lane,

    input  logic [2:0]        ld_mode,
    input  logic [1:0]        ld_off,
    input  logic [LANE_W-1:0] rdata_word,
    output logic [LANE_W-1:0] rdata_ext
);

    mem_mode_e req_mode;
    mem_mode_e rsp_mode;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_mode = mem_mode_e'(mode);
    assign rsp_mode = mem_mode_e'(ld_mode);

    // Request side: legality, lane mask and store replication
    always_comb begin
        legal      = 1'b0;
        be         = '0;
        wdata_lane = wdata;
        case (req_mode)
            MM_B: begin
                legal      = 1'b1;
                be         = BE_W'(4'b0001 << off);
                wdata_lane = {4{wdata[7:0]}};
            end
            MM_BU: begin
                legal = !is_store;
                be    = BE_W'(4'b0001 << off);
            end
            MM_H: begin
                legal      = !off[0];
                be         = BE_W'(4'b0011 << off);
                wdata_lane = {2{wdata[15:0]}};
            end
            MM_HU: begin
                legal = !is_store && !off[0];
                be    = BE_W'(4'b0011 << off);
            end
            MM_W: begin
                legal = (off == 2'b00);
                be    = BE_WORD;
            end
            default: begin
                legal = 1'b0;
                be    = '0;
            end
        endcase
    end

    // Response side: pick the addressed lane; offset 3 halves are never legal
    always_comb begin
        ld_byte = rdata_word[7:0];
        ld_half = rdata_word[15:0];
        case (ld_off)
            2'd0: begin ld_byte = rdata_word[7:0];   ld_half = rdata_word[15:0];  end
            2'd1: begin ld_byte = rdata_word[15:8];  ld_half = rdata_word[23:8];  end
            2'd2: begin ld_byte = rdata_word[23:16]; ld_half = rdata_word[31:16]; end
            default: begin
                ld_byte = rdata_word[31:24];
                ld_half = 16'(rdata_word[31:24]);
            end
        endcase
    end

    always_comb begin
        rdata_ext = rdata_word;
        case (rsp_mode)
            MM_B:    rdata_ext = {{24{ld_byte[7]}}, ld_byte};
            MM_BU:   rdata_ext = {24'h0, ld_byte};
            MM_H:    rdata_ext = {{16{ld_half[15]}}, ld_half};
            MM_HU:   rdata_ext = {16'h0, ld_half};
            default: rdata_ext = rdata_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Load/store responder: turns one decoded memory access into one handshaked
// word-bus transaction, holding the pipeline with stall until it completes.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        mem_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    lsu_mem_responder_if.master bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0] state;
    logic [1:0] state_d;
    logic       acc;
    logic       start;
    logic       legal;

    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata_lane;
    logic [DATA_W-1:0] rdata_ext;
    logic [2:0]        mode_q;
    logic [1:0]        off_q;

    assign acc = rd_en | wr_en;

    lsu_align u_align (
        .mode       (mem_mode),
        .off        (addr[1:0]),
        .is_store   (wr_en),
        .wdata      (wdata),
        .legal      (legal),
        .be         (be),
        .wdata_lane (wdata_lane),
        .ld_mode    (mode_q),
        .ld_off     (off_q),
        .rdata_word (bus.bus_rdata),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state plus the combinational pipeline-facing flags
    always_comb begin
        state_d    = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (legal) begin
                        stall   = 1'b1;
                        start   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request fields are captured once at launch and held until ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            mode_q        <= 3'b000;
            off_q         <= 2'b00;
            rdata         <= '0;
        end else begin
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= wr_en;
                bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                bus.bus_be    <= be;
                bus.bus_wdata <= wdata_lane;
                mode_q        <= mem_mode;
                off_q         <= addr[1:0];
            end
            if (state == S_REQ && bus.bus_ack) begin
                bus.bus_req <= 1'b0;
                if (!bus.bus_we) rdata <= rdata_ext;
            end
        end
    end

endmodule
